msg_assembler_fifo: RTL and testbench
=====================================

MSG_ASSEMBLER_FIFO -- requirements
Module: msg_assembler_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of 320-bit message slots in the output FIFO (power of two, minimum 2).
REQ-002 SHALL have parameter MSG_BYTES, default 40, meaning the number of bytes per message (40 x 8 = 320 bits).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: asynchronous, active-high reset (asserted = 1).
REQ-005 SHALL have port in_valid, input, 1 bit: a byte is presented on in_data.
REQ-006 SHALL have port in_sop, input, 1 bit: the presented byte is byte 0 of a message.
REQ-007 SHALL have port in_data, input, 8 bits: the message byte.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-009 SHALL have port system_free, input, 1 bit: the downstream order-book pair can consume the head message.
REQ-010 SHALL have port buffer_not_empty, output, 1 bit: ff_buffer holds a valid message.
REQ-011 SHALL have port ff_buffer, output, 320 bits: the head-of-FIFO message.
REQ-012 SHALL have port drop_count, output, 16 bits: a saturating count of discarded messages.
REQ-013 SHALL have port fifo_level, output, clog2(DEPTH)+1 bits: the current FIFO occupancy.

Function
REQ-014 SHALL accept a byte when in_valid && in_ready are both high.
REQ-015 SHALL drive in_ready = (fifo_level < DEPTH), registered-state based, with no combinational path from system_free.
REQ-016 SHALL keep a byte index 0..MSG_BYTES-1 and write byte k to bits [319-8k : 312-8k] of the assembly register (byte 0 is the MSB).
REQ-017 SHALL, when an accepted byte has in_sop=1, force its index to 0; if the previous index was not 0, the partial message is discarded and drop_count increments.
REQ-018 SHALL ignore (not store) an accepted byte with in_sop=0 while idle, i.e. after reset or after a completed message and before the next sop.
REQ-019 SHALL complete a message when byte MSG_BYTES-1 is accepted, then return the index to idle, waiting for the next sop.
REQ-020 SHALL classify a completed message by its side byte, bits [151:144]: 8'h42 (bid) or 8'h44 (ask) is pushed into the FIFO; any other value is dropped and drop_count increments.
REQ-021 SHALL evaluate the side byte on the complete message, including the final byte's contribution in the same cycle.
REQ-022 SHALL pop the FIFO on any cycle where buffer_not_empty && system_free are both high.
REQ-023 SHALL make a pushed message visible on ff_buffer with buffer_not_empty high in the cycle after the final byte is accepted (1-cycle latency when the FIFO is empty).
REQ-024 SHALL, on a simultaneous push and pop, leave fifo_level unchanged, advance the head, and write the new tail.
REQ-025 SHALL never accept a byte when the FIFO is full, so a push into a full FIFO cannot occur.
REQ-026 SHALL hold ff_buffer stable while buffer_not_empty=1 and no pop occurs.
REQ-027 SHALL wrap the read and write pointers modulo DEPTH.
REQ-028 SHALL saturate drop_count at 16'hFFFF.
REQ-029 SHALL, when two drop causes coincide in one cycle, increment drop_count by 1 only.

Reset
REQ-030 SHALL, on resetn=1 (asynchronous), clear the pointers, set fifo_level=0, set buffer_not_empty=0, set the index to idle, clear the assembly register, set drop_count=0, and drive ff_buffer=0.
REQ-031 SHALL discard any partial message or queued messages when reset is asserted mid-operation; there is no partial output.
REQ-032 SHALL drive in_ready=1 in the first cycle after reset deasserts.

Structure
REQ-033 SHALL take MSG_W=320, SIDE_HI=151, SIDE_LO=144, SIDE_BID=8'h42 and SIDE_ASK=8'h44 from shared package hft_pkg, also used by the order-book stages.
REQ-034 SHALL instantiate one sub-module, msg_fifo (a parameterised DEPTH x MSG_W synchronous FIFO with push, pop, head, level); assembly and classification logic stays in msg_assembler_fifo.

Verification
REQ-035 SHALL verify: a 40-byte message with sop, bytes 0x00..0x27 and byte 21 = 0x42 -> buffer_not_empty=1 one cycle after the last byte, ff_buffer[319:312]=0x00, ff_buffer[7:0]=0x27.
REQ-036 SHALL verify: same message with byte 21 = 0x55 -> no push, drop_count=1, buffer_not_empty stays 0.
REQ-037 SHALL verify: 5 valid messages with system_free=0 -> fifo_level=4, in_ready=0 after the 4th message; raising system_free for 1 cycle -> level 3, in_ready=1, 5th message accepted.
REQ-038 SHALL verify: sop at byte index 17 -> drop_count=1, and the new message completes 39 bytes later and is pushed.
REQ-039 SHALL verify: push and pop in the same cycle with level=2 -> level stays 2, and head order is preserved across pointer wrap.
REQ-040 SHALL verify: resetn pulse mid-message with 3 messages queued -> next cycle level=0, buffer_not_empty=0, drop_count=0, ff_buffer=0.

Source files
------------

// File: rtl/hft_pkg.sv
// -----------------------------------------------------------------------------
// hft_pkg
// Shared constants for the market-data message path: message width and the
// location and legal values of the side byte. The order-book stages import the
// same package, so changing a field position here updates every stage.
// -----------------------------------------------------------------------------
package hft_pkg;

    localparam int MSG_W   = 320;
    localparam int SIDE_HI = 151;
    localparam int SIDE_LO = 144;

    localparam logic [7:0] SIDE_BID = 8'h42;
    localparam logic [7:0] SIDE_ASK = 8'h44;

    // True when the side byte names a book the downstream pair can handle.
    function automatic logic is_book_side(input logic [7:0] side);
        return (side == SIDE_BID) || (side == SIDE_ASK);
    endfunction

endpackage

// File: rtl/msg_fifo.sv
// -----------------------------------------------------------------------------
// msg_fifo
// DEPTH x MSG_W synchronous FIFO with a first-word-fall-through head.
// Ports:
//   clk, resetn    - clock, asynchronous active-high reset
//   push/push_data - write push_data at the tail (ignored when full)
//   pop            - advance the head (ignored when empty)
//   head           - message at the head, all zeros while empty
//   level          - current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module msg_fifo
    import hft_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [MSG_W-1:0]         push_data,
    input  logic                     pop,
    output logic [MSG_W-1:0]         head,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [MSG_W-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: storage is deliberately not reset; stale slots are never visible
    // because the head output is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/msg_assembler_fifo.sv
// -----------------------------------------------------------------------------
// msg_assembler_fifo
// Assembles a byte stream into MSG_BYTES-byte messages (byte 0 is the MSB),
// keeps only bid/ask messages and queues them for the order-book pair.
// Ports:
//   clk, resetn              - clock, asynchronous active-high reset
//   in_valid/in_sop/in_data  - byte stream; in_sop marks byte 0
//   in_ready                 - byte accepted this cycle when in_valid is high
//   system_free              - downstream consumes the head message
//   buffer_not_empty         - ff_buffer holds a valid message
//   ff_buffer                - head-of-FIFO message
//   drop_count               - saturating count of discarded messages
//   fifo_level               - current FIFO occupancy
// -----------------------------------------------------------------------------
module msg_assembler_fifo
    import hft_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MSG_BYTES = 40
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    input  logic                     in_sop,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    input  logic                     system_free,
    output logic                     buffer_not_empty,
    output logic [MSG_W-1:0]         ff_buffer,
    output logic [15:0]              drop_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int IW = $clog2(MSG_BYTES);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [MSG_W-1:0] asm_q;
    logic [MSG_W-1:0] asm_next;
    logic [IW-1:0]    idx_q;
    logic             active_q;   // a message is in progress (not idle)

    logic             accept;
    logic             store;
    logic [IW-1:0]    eff_idx;
    logic             last;
    logic             side_ok;
    logic             push;
    logic             drop;

    // Ready depends only on registered occupancy, never on system_free.
    assign in_ready = (fifo_level < LW'(DEPTH));
    assign accept   = in_valid && in_ready;
    // Bytes without sop while idle are accepted but not stored.
    assign store    = accept && (in_sop || active_q);
    assign eff_idx  = in_sop ? '0 : idx_q;
    assign last     = store && (eff_idx == IW'(MSG_BYTES - 1));

    // NOTE: combinational logic uses blocking '=' with a default assignment
    // first, so every path assigns asm_next and no latch is inferred.
    always_comb begin
        asm_next = asm_q;
        if (store) begin
            asm_next[MSG_W - 1 - 8 * int'(eff_idx) -: 8] = in_data;
        end
    end

    // Side byte is taken from asm_next so the final byte counts this cycle.
    assign side_ok = is_book_side(asm_next[SIDE_HI:SIDE_LO]);
    assign push    = last && side_ok;
    // Sop over a partial and an unwanted side can coincide: still one drop.
    assign drop    = (accept && in_sop && active_q && (idx_q != '0))
                   || (last && !side_ok);

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            asm_q      <= '0;
            idx_q      <= '0;
            active_q   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (store) begin
                asm_q <= asm_next;
                if (last) begin
                    idx_q    <= '0;
                    active_q <= 1'b0;
                end else begin
                    idx_q    <= eff_idx + IW'(1);
                    active_q <= 1'b1;
                end
            end
            if (drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    assign buffer_not_empty = (fifo_level != '0);

    msg_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (asm_next),
        .pop       (buffer_not_empty && system_free),
        .head      (ff_buffer),
        .level     (fifo_level)
    );

endmodule

// File: tb/tb_msg_assembler_fifo.sv
// -----------------------------------------------------------------------------
// tb_msg_assembler_fifo
// Directed bench for msg_assembler_fifo. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_msg_assembler_fifo;

    logic         clk = 1'b0;
    logic         resetn = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_sop = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         in_ready;
    logic         system_free = 1'b0;
    logic         buffer_not_empty;
    logic [319:0] ff_buffer;
    logic [15:0]  drop_count;
    logic [2:0]   fifo_level;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    msg_assembler_fifo #(
        .DEPTH     (4),
        .MSG_BYTES (40)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .in_valid         (in_valid),
        .in_sop           (in_sop),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .system_free      (system_free),
        .buffer_not_empty (buffer_not_empty),
        .ff_buffer        (ff_buffer),
        .drop_count       (drop_count),
        .fifo_level       (fifo_level)
    );

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
            $error("%s differs from expected value", tag);
        end
    endtask

    // Byte k of a test message: base+k, except byte 21 (the side byte).
    function automatic logic [7:0] msg_byte(input logic [7:0] base, input logic [7:0] side, input int k);
        return (k == 21) ? side : base + 8'(k);
    endfunction

    function automatic logic [319:0] make_msg(input logic [7:0] base, input logic [7:0] side);
        logic [319:0] m;
        m = '0;
        for (int k = 0; k < 40; k++) m[319 - 8*k -: 8] = msg_byte(base, side, k);
        return m;
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_byte(input logic sop, input logic [7:0] data);
        int waited;
        waited = 0;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("in_ready_timeout", 320'(in_ready), 320'd1);
        in_valid = 1'b1;
        in_sop   = sop;
        in_data  = data;
        @(negedge clk);
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic send_range(input logic [7:0] base, input logic [7:0] side,
                              input int first, input int last_k, input logic use_sop);
        for (int k = first; k <= last_k; k++)
            send_byte(use_sop && (k == 0), msg_byte(base, side, k));
    endtask

    task automatic send_msg(input logic [7:0] base, input logic [7:0] side);
        send_range(base, side, 0, 39, 1'b1);
    endtask

    task automatic pop_one();
        system_free = 1'b1;
        @(negedge clk);
        system_free = 1'b0;
    endtask

    initial begin
        // ---- reset state ----
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 320'(in_ready), 320'd1);
        check("rst_level", 320'(fifo_level), 320'd0);
        check("rst_bne", 320'(buffer_not_empty), 320'd0);
        check("rst_drop", 320'(drop_count), 320'd0);
        check("rst_ff", ff_buffer, 320'd0);

        // ---- bid message, 1-cycle latency ----
        send_msg(8'h00, 8'h42);
        check("t1_bne", 320'(buffer_not_empty), 320'd1);
        check("t1_msb", 320'(ff_buffer[319:312]), 320'h00);
        check("t1_lsb", 320'(ff_buffer[7:0]), 320'h27);
        check("t1_ff", ff_buffer, make_msg(8'h00, 8'h42));
        check("t1_level", 320'(fifo_level), 320'd1);
        @(negedge clk);
        check("t1_hold", ff_buffer, make_msg(8'h00, 8'h42));
        pop_one();
        check("t1_pop_level", 320'(fifo_level), 320'd0);
        check("t1_pop_bne", 320'(buffer_not_empty), 320'd0);
        check("t1_pop_ff", ff_buffer, 320'd0);

        // ---- unknown side byte is dropped ----
        send_msg(8'h00, 8'h55);
        check("t2_drop", 320'(drop_count), 320'd1);
        check("t2_bne", 320'(buffer_not_empty), 320'd0);
        @(negedge clk);
        check("t2_bne_later", 320'(buffer_not_empty), 320'd0);

        // ---- fill to DEPTH, backpressure, then one pop ----
        send_msg(8'h10, 8'h42);
        send_msg(8'h20, 8'h44);
        send_msg(8'h30, 8'h42);
        send_msg(8'h40, 8'h44);
        check("t3_full_level", 320'(fifo_level), 320'd4);
        check("t3_full_ready", 320'(in_ready), 320'd0);
        check("t3_full_head", ff_buffer, make_msg(8'h10, 8'h42));
        pop_one();
        check("t3_pop_level", 320'(fifo_level), 320'd3);
        check("t3_pop_ready", 320'(in_ready), 320'd1);
        check("t3_pop_head", ff_buffer, make_msg(8'h20, 8'h44));
        send_msg(8'h50, 8'h42);
        check("t3_fifth_level", 320'(fifo_level), 320'd4);
        check("t3_fifth_drop", 320'(drop_count), 320'd1);
        check("t3_d0", ff_buffer, make_msg(8'h20, 8'h44)); pop_one();
        check("t3_d1", ff_buffer, make_msg(8'h30, 8'h42)); pop_one();
        check("t3_d2", ff_buffer, make_msg(8'h40, 8'h44)); pop_one();
        check("t3_d3", ff_buffer, make_msg(8'h50, 8'h42)); pop_one();
        check("t3_empty", 320'(buffer_not_empty), 320'd0);

        // ---- sop at index 17 discards the partial ----
        send_range(8'h60, 8'h42, 0, 16, 1'b1);
        check("t4_partial_drop", 320'(drop_count), 320'd1);
        send_range(8'h70, 8'h44, 0, 0, 1'b1);
        check("t4_sop_drop", 320'(drop_count), 320'd2);
        send_range(8'h70, 8'h44, 1, 38, 1'b0);
        check("t4_not_yet", 320'(buffer_not_empty), 320'd0);
        send_range(8'h70, 8'h44, 39, 39, 1'b0);
        check("t4_bne", 320'(buffer_not_empty), 320'd1);
        check("t4_ff", ff_buffer, make_msg(8'h70, 8'h44));
        pop_one();

        // ---- simultaneous push and pop at level 2, across pointer wrap ----
        send_msg(8'h80, 8'h42);
        send_msg(8'h90, 8'h44);
        check("t5_level2", 320'(fifo_level), 320'd2);
        send_range(8'hA0, 8'h42, 0, 38, 1'b1);
        system_free = 1'b1;
        send_byte(1'b0, msg_byte(8'hA0, 8'h42, 39));
        system_free = 1'b0;
        check("t5_level_kept", 320'(fifo_level), 320'd2);
        check("t5_head_b", ff_buffer, make_msg(8'h90, 8'h44));
        pop_one();
        check("t5_head_c", ff_buffer, make_msg(8'hA0, 8'h42));
        check("t5_level1", 320'(fifo_level), 320'd1);
        pop_one();
        check("t5_level0", 320'(fifo_level), 320'd0);

        // ---- reset mid-message with three queued ----
        send_msg(8'hB0, 8'h42);
        send_msg(8'hC0, 8'h44);
        send_msg(8'hD0, 8'h42);
        send_range(8'hE0, 8'h42, 0, 9, 1'b1);
        check("t6_level3", 320'(fifo_level), 320'd3);
        resetn = 1'b1;
        #2;
        check("t6_async_level", 320'(fifo_level), 320'd0);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("t6_level", 320'(fifo_level), 320'd0);
        check("t6_bne", 320'(buffer_not_empty), 320'd0);
        check("t6_drop", 320'(drop_count), 320'd0);
        check("t6_ff", ff_buffer, 320'd0);
        check("t6_ready", 320'(in_ready), 320'd1);

        // ---- tail of the old message without sop is ignored while idle ----
        send_range(8'hE0, 8'h42, 10, 39, 1'b0);
        check("t7_idle_bne", 320'(buffer_not_empty), 320'd0);
        check("t7_idle_drop", 320'(drop_count), 320'd0);
        send_msg(8'hF0, 8'h44);
        check("t7_ff", ff_buffer, make_msg(8'hF0, 8'h44));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
